// File: rtl/gol_grid.sv
// Game-of-Life grid engine: rows are loaded in IDLE, a run computes one whole generation per clock, and rows are read back through a registered port.
// Optional macro GOL_STABLE_DETECT_EN ends a run early when a generation leaves the grid unchanged.
module gol_grid #(
   parameter int         WIDTH        = 8,
   parameter int         HEIGHT       = 8,
   parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
   parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
   parameter int         WRAP         = 1
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_load_valid,
   input  logic [WIDTH-1:0]          i_load_row,
   output logic                      o_load_ready,
   input  logic                      i_start,
   input  logic [15:0]               i_steps,
   input  logic                      i_abort,
   output logic                      o_busy,
   output logic                      o_done,
   output logic [15:0]               o_gen,
   output logic                      o_stable,
   input  logic [$clog2(HEIGHT)-1:0] i_rd_row,
   output logic [WIDTH-1:0]          o_rd_data
);

   localparam int RW = $clog2(HEIGHT);
   localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                        state, state_nx;
   logic [HEIGHT-1:0][WIDTH-1:0]  grid, grid_nx;
   logic [RW-1:0]                 load_ptr;
   logic [15:0]                   remaining;
   logic [15:0]                   gen;
   logic                          stable_hit;

   // Neighbour offsets are resolved at elaboration; without WRAP, off-grid neighbours read as dead.
   for (genvar r = 0; r < HEIGHT; r++) begin : g_row
      for (genvar c = 0; c < WIDTH; c++) begin : g_col
         localparam int RU   = (r == 0) ? HEIGHT - 1 : r - 1;
         localparam int RD   = (r == HEIGHT - 1) ? 0 : r + 1;
         localparam int CL   = (c == 0) ? WIDTH - 1 : c - 1;
         localparam int CR   = (c == WIDTH - 1) ? 0 : c + 1;
         localparam bit OK_U = (WRAP != 0) || (r > 0);
         localparam bit OK_D = (WRAP != 0) || (r < HEIGHT - 1);
         localparam bit OK_L = (WRAP != 0) || (c > 0);
         localparam bit OK_R = (WRAP != 0) || (c < WIDTH - 1);

         logic [7:0] nb;
         logic [3:0] cnt;

         assign nb[0] = OK_U && OK_L && grid[RU][CL];
         assign nb[1] = OK_U &&         grid[RU][c];
         assign nb[2] = OK_U && OK_R && grid[RU][CR];
         assign nb[3] =         OK_L && grid[r][CL];
         assign nb[4] =         OK_R && grid[r][CR];
         assign nb[5] = OK_D && OK_L && grid[RD][CL];
         assign nb[6] = OK_D &&         grid[RD][c];
         assign nb[7] = OK_D && OK_R && grid[RD][CR];

         assign cnt = 4'(nb[0]) + 4'(nb[1]) + 4'(nb[2]) + 4'(nb[3])
                    + 4'(nb[4]) + 4'(nb[5]) + 4'(nb[6]) + 4'(nb[7]);

         assign grid_nx[r][c] = grid[r][c] ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
      end
   end

`ifdef GOL_STABLE_DETECT_EN
   assign stable_hit = (grid_nx == grid);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_stable <= 1'b0;
      end else if (state == IDLE && i_start) begin
         o_stable <= 1'b0;
      end else if (state == RUN && !i_abort && stable_hit) begin
         o_stable <= 1'b1;
      end
   end
`else
   assign stable_hit = 1'b0;
   assign o_stable   = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               state_nx = (i_steps == 16'd0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (i_abort) begin
               state_nx = IDLE;
            end else if (stable_hit || remaining == 16'd1) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // A row write and a start in the same IDLE cycle both take effect; the start then rewinds the load pointer.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         grid      <= '0;
         load_ptr  <= '0;
         remaining <= '0;
         gen       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_load_valid) begin
                  grid[load_ptr] <= i_load_row;
                  load_ptr       <= (load_ptr == LAST_ROW) ? '0 : load_ptr + RW'(1);
               end
               if (i_start) begin
                  remaining <= i_steps;
                  gen       <= '0;
                  load_ptr  <= '0;
               end
            end
            RUN: begin
               if (!i_abort && !stable_hit) begin
                  grid      <= grid_nx;
                  gen       <= gen + 16'd1;
                  remaining <= remaining - 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_rd_data <= '0;
      end else if (int'(i_rd_row) < HEIGHT) begin
         o_rd_data <= grid[i_rd_row];
      end else begin
         o_rd_data <= '0;
      end
   end

   assign o_load_ready = (state == IDLE);
   assign o_busy       = (state == RUN);
   assign o_done       = (state == DONE);
   assign o_gen        = gen;

endmodule

// File: tb/tb_gol_grid.sv
// Self-checking bench for gol_grid: a toroidal and a flat 8x8 instance run the same vectors against a reference Life model.
module tb_gol_grid;

   typedef logic [7:0][7:0] grid_t;

   typedef struct {
      grid_t       init;
      logic [15:0] steps;
      bit          merge;
      bit          noise;
      int          abort_at;
      bit          has_want;
      grid_t       want;
   } vec_t;

   typedef struct {
      grid_t       ga, gb;
      logic [15:0] gen_a, gen_b;
      int          lat_a, lat_b, cnt_a, cnt_b;
      logic        stb_a, stb_b;
   } exp_t;

   typedef struct {
      int         row;
      logic [7:0] a, b;
   } rd_exp_t;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_load_valid = 1'b0;
   logic [7:0]  i_load_row = '0;
   logic        i_start = 1'b0;
   logic [15:0] i_steps = '0;
   logic        i_abort = 1'b0;
   logic [2:0]  i_rd_row = '0;

   logic        a_load_ready, a_busy, a_done, a_stable;
   logic [15:0] a_gen;
   logic [7:0]  a_rd_data;
   logic        b_load_ready, b_busy, b_done, b_stable;
   logic [15:0] b_gen;
   logic [7:0]  b_rd_data;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t    exp_q[$];
   rd_exp_t rd_q[$];
   vec_t    vecs[8];

   gol_grid #(.WIDTH(8), .HEIGHT(8), .WRAP(1)) dut_wrap (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_load_valid(i_load_valid), .i_load_row(i_load_row), .o_load_ready(a_load_ready),
      .i_start(i_start), .i_steps(i_steps), .i_abort(i_abort),
      .o_busy(a_busy), .o_done(a_done), .o_gen(a_gen), .o_stable(a_stable),
      .i_rd_row(i_rd_row), .o_rd_data(a_rd_data)
   );

   gol_grid #(.WIDTH(8), .HEIGHT(8), .WRAP(0)) dut_flat (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_load_valid(i_load_valid), .i_load_row(i_load_row), .o_load_ready(b_load_ready),
      .i_start(i_start), .i_steps(i_steps), .i_abort(i_abort),
      .o_busy(b_busy), .o_done(b_done), .o_gen(b_gen), .o_stable(b_stable),
      .i_rd_row(i_rd_row), .o_rd_data(b_rd_data)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference B3/S23 rule written directly from neighbour coordinates.
   function automatic grid_t model_step(input grid_t g, input bit wrap);
      grid_t nx;
      nx = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            int n;
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  int rr, cc;
                  if (dr == 0 && dc == 0) continue;
                  rr = r + dr;
                  cc = c + dc;
                  if (wrap) begin
                     rr = (rr + 8) % 8;
                     cc = (cc + 8) % 8;
                  end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
                     continue;
                  end
                  n += int'(g[rr][cc]);
               end
            end
            nx[r][c] = g[r][c] ? (n == 2 || n == 3) : (n == 3);
         end
      end
      return nx;
   endfunction

   task automatic predict(input vec_t v, input bit wrap, output grid_t g, output logic [15:0] gen,
                          output int lat, output int cnt, output logic stb);
      grid_t nx;
      int    n_gens;
      g      = v.init;
      gen    = '0;
      stb    = 1'b0;
      n_gens = (v.abort_at != 0) ? v.abort_at - 1 : int'(v.steps);
      for (int s = 0; s < n_gens; s++) begin
         nx = model_step(g, wrap);
`ifdef GOL_STABLE_DETECT_EN
         if (nx == g) begin
            stb = 1'b1;
            break;
         end
`endif
         g   = nx;
         gen = gen + 16'd1;
      end
      if (v.abort_at != 0) begin
         lat = -1;
         cnt = 0;
      end else begin
         lat = stb ? int'(gen) + 1 : int'(gen);
         cnt = 1;
      end
   endtask

   task automatic read_grid(input string tag, input grid_t ea, input grid_t eb,
                            output grid_t rd_a, output grid_t rd_b);
      rd_exp_t x;
      for (int r = 0; r < 8; r++) begin
         i_rd_row = 3'(r);
         x.row = r;
         x.a   = ea[r];
         x.b   = eb[r];
         rd_q.push_back(x);
         @(posedge i_clk); #1;
         x = rd_q.pop_front();
         rd_a[r] = a_rd_data;
         rd_b[r] = b_rd_data;
         check_output($sformatf("%s wrap row%0d", tag, x.row), 64'(a_rd_data), 64'(x.a));
         check_output($sformatf("%s flat row%0d", tag, x.row), 64'(b_rd_data), 64'(x.b));
      end
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      exp_t  e;
      grid_t rd_a, rd_b;
      int    lat_a, lat_b, cnt_a, cnt_b;
      string tag;
      tag = $sformatf("v%0d", idx);
      predict(v, 1'b1, e.ga, e.gen_a, e.lat_a, e.cnt_a, e.stb_a);
      predict(v, 1'b0, e.gb, e.gen_b, e.lat_b, e.cnt_b, e.stb_b);
      exp_q.push_back(e);

      i_abort = v.noise;
      for (int r = 0; r < 8; r++) begin
         i_load_valid = 1'b1;
         i_load_row   = v.init[r];
         if (r == 7 && v.merge) begin
            i_start = 1'b1;
            i_steps = v.steps;
         end
         @(posedge i_clk); #1;
      end
      i_load_valid = 1'b0;
      if (!v.merge) begin
         i_start = 1'b1;
         i_steps = v.steps;
         @(posedge i_clk); #1;
      end
      i_start = 1'b0;
      i_abort = 1'b0;

      lat_a = -1; lat_b = -1; cnt_a = 0; cnt_b = 0;
      for (int k = 0; k < int'(v.steps) + 4; k++) begin
         if (a_done) begin cnt_a++; if (lat_a < 0) lat_a = k; end
         if (b_done) begin cnt_b++; if (lat_b < 0) lat_b = k; end
         if (v.noise && k == 1) begin
            i_load_valid = 1'b1;
            i_load_row   = 8'hFF;
            i_start      = 1'b1;
         end
         if (v.abort_at != 0 && k == v.abort_at - 1) i_abort = 1'b1;
         @(posedge i_clk); #1;
         i_load_valid = 1'b0;
         i_start      = 1'b0;
         i_abort      = 1'b0;
         if (v.abort_at != 0 && k == v.abort_at - 1) begin
            check_output({tag, " abort ready"}, 64'({a_load_ready, b_load_ready}), 64'(2'b11));
            check_output({tag, " abort gen"}, 64'(a_gen), 64'(v.abort_at - 1));
         end
      end

      e = exp_q.pop_front();
      check_output({tag, " wrap latency"}, 64'(lat_a), 64'(e.lat_a));
      check_output({tag, " flat latency"}, 64'(lat_b), 64'(e.lat_b));
      check_output({tag, " wrap done pulses"}, 64'(cnt_a), 64'(e.cnt_a));
      check_output({tag, " flat done pulses"}, 64'(cnt_b), 64'(e.cnt_b));
      check_output({tag, " wrap gen"}, 64'(a_gen), 64'(e.gen_a));
      check_output({tag, " flat gen"}, 64'(b_gen), 64'(e.gen_b));
      check_output({tag, " wrap stable"}, 64'(a_stable), 64'(e.stb_a));
      check_output({tag, " flat stable"}, 64'(b_stable), 64'(e.stb_b));
      check_output({tag, " idle flags"}, 64'({a_busy, b_busy, a_load_ready, b_load_ready}), 64'(4'b0011));
      read_grid(tag, e.ga, e.gb, rd_a, rd_b);
      if (v.has_want) check_output({tag, " wrap known result"}, 64'(rd_a), 64'(v.want));
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      grid_t blinker, blinker_v, glider, corner, corner_nx, edge_h, edge_v, block;
      grid_t rd_a, rd_b;
      int    cnt;

      blinker = '0;  blinker[3] = 8'b00011100;
      blinker_v = '0;
      blinker_v[2] = 8'b00001000; blinker_v[3] = 8'b00001000; blinker_v[4] = 8'b00001000;
      glider = '0;
      glider[0] = 8'b00000010; glider[1] = 8'b00000100; glider[2] = 8'b00000111;
      corner = '0;   corner[0] = 8'b00000011; corner[1] = 8'b00000001;
      corner_nx = '0; corner_nx[0] = 8'b00000011; corner_nx[1] = 8'b00000011;
      edge_h = '0;   edge_h[3] = 8'b10000011;
      edge_v = '0;
      edge_v[2] = 8'b00000001; edge_v[3] = 8'b00000001; edge_v[4] = 8'b00000001;
      block = '0;    block[3] = 8'b00011000; block[4] = 8'b00011000;

      //          init     steps  merge noise abort has_want want
      vecs[0] = '{blinker, 16'd1,  1'b0, 1'b0, 0, 1'b1, blinker_v};
      vecs[1] = '{blinker, 16'd2,  1'b1, 1'b0, 0, 1'b1, blinker};
      vecs[2] = '{glider,  16'd32, 1'b0, 1'b1, 0, 1'b1, glider};
      vecs[3] = '{corner,  16'd1,  1'b1, 1'b0, 0, 1'b1, corner_nx};
      vecs[4] = '{edge_h,  16'd1,  1'b0, 1'b0, 0, 1'b1, edge_v};
      vecs[5] = '{glider,  16'd0,  1'b0, 1'b0, 0, 1'b1, glider};
      vecs[6] = '{block,   16'd10, 1'b0, 1'b0, 0, 1'b1, block};
      vecs[7] = '{glider,  16'd5,  1'b0, 1'b0, 3, 1'b0, '0};

      #2;
      check_output("reset flags", 64'({a_busy, a_done, a_stable, a_load_ready}), 64'(4'b0001));
      check_output("reset gen", 64'(a_gen), 64'(0));
      check_output("reset rd_data", 64'(a_rd_data), 64'(0));
      @(posedge i_clk); @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      read_grid("reset", '0, '0, rd_a, rd_b);

      for (int i = 0; i < 8; i++) apply_stimulus(vecs[i], i);

      // Reset dropped in the middle of a run
      for (int r = 0; r < 8; r++) begin
         i_load_valid = 1'b1;
         i_load_row   = glider[r];
         @(posedge i_clk); #1;
      end
      i_load_valid = 1'b0;
      i_start = 1'b1;
      i_steps = 16'd20;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      repeat (5) @(posedge i_clk);
      #1;
      check_output("midrun busy", 64'(a_busy), 64'(1));
      i_reset_n = 1'b0;
      #2;
      check_output("midrun reset flags", 64'({a_busy, a_done, a_stable, a_load_ready}), 64'(4'b0001));
      check_output("midrun reset gen", 64'(a_gen), 64'(0));
      check_output("midrun reset rd_data", 64'({a_rd_data, b_rd_data}), 64'(0));
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 25; k++) begin
         if (a_done || b_done) cnt++;
         @(posedge i_clk); #1;
      end
      check_output("midrun no done", 64'(cnt), 64'(0));
      read_grid("midrun", '0, '0, rd_a, rd_b);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gol_grid.md
GOL_GRID -- requirements
Module: gol_grid

Interface
REQ-001 Parameter WIDTH, default 8: grid columns, range 3..64.
REQ-002 Parameter HEIGHT, default 8: grid rows, range 3..64.
REQ-003 Parameter BIRTH_MASK [8:0], default 9'b000001000: a dead cell with n live neighbours is born when bit n is 1.
REQ-004 Parameter SURVIVE_MASK [8:0], default 9'b000001100: a live cell with n live neighbours stays alive when bit n is 1.
REQ-005 Parameter WRAP, default 1: 1 = toroidal edges, 0 = cells outside the grid count as dead.
REQ-006 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 i_reset_n  in  1  asynchronous, active-low reset.
REQ-008 i_load_valid  in  1  row write strobe.
REQ-009 i_load_row  in  WIDTH  row data; bit c is column c.
REQ-010 o_load_ready  out  1  high when a row write is accepted (state IDLE).
REQ-011 i_start  in  1  begin a run.
REQ-012 i_steps  in  16  generation count for the run.
REQ-013 i_abort  in  1  terminate a run.
REQ-014 o_busy  out  1  high in RUN.
REQ-015 o_done  out  1  one-cycle pulse when a run completes.
REQ-016 o_gen  out  16  generations computed since the last accepted start.
REQ-017 o_stable  out  1  stable-pattern flag (see Configuration).
REQ-018 i_rd_row  in  clog2(HEIGHT)  readout row index.
REQ-019 o_rd_data  out  WIDTH  registered readout data.

Function
REQ-020 FSM states SHALL be IDLE, RUN and DONE.
REQ-021 IDLE: each i_load_valid cycle SHALL write i_load_row to the row at the load pointer and increment the pointer, wrapping from HEIGHT-1 to 0.
REQ-022 IDLE with i_start: latch i_steps, clear o_gen and o_stable, reset the load pointer to 0, and go to RUN; if i_steps==0, go to DONE instead.
REQ-023 IDLE with i_start and i_load_valid in the same cycle: the row write SHALL complete first and the start SHALL also be taken.
REQ-024 RUN: each cycle SHALL compute one full generation for all cells in parallel, increment o_gen, and decrement the remaining count.
REQ-025 Rule: n = live count of the 8 neighbours (0..8, 4-bit); next = alive ? SURVIVE_MASK[n] : BIRTH_MASK[n].
REQ-026 RUN: when the remaining count reaches 0, go to DONE. A start at edge t with i_steps=N SHALL give o_done high in cycle t+N+1.
REQ-027 DONE: assert o_done for exactly one cycle, then return to IDLE.
REQ-028 i_abort in RUN SHALL take priority over the generation update that cycle: the grid is held, the FSM goes to IDLE, and o_done is not pulsed; i_abort SHALL be ignored outside RUN.
REQ-029 i_start outside IDLE SHALL be ignored; i_load_valid outside IDLE SHALL be ignored; o_load_ready = (state==IDLE).
REQ-030 o_gen SHALL wrap from 0xFFFF to 0x0000.
REQ-031 o_rd_data SHALL equal the row at i_rd_row one cycle later, valid in every state; an index >= HEIGHT SHALL return 0.

Reset
REQ-032 When i_reset_n is low: all grid cells 0, load pointer 0, state IDLE, o_busy=0, o_done=0, o_gen=0, o_stable=0, o_rd_data=0, o_load_ready=1.
REQ-033 Reset asserted mid-RUN SHALL discard the run immediately; no o_done pulse follows.

Configuration
REQ-034 With GOL_STABLE_DETECT_EN defined: if a computed generation in RUN equals the current grid, then o_stable=1, o_gen is not incremented for that generation, and the FSM goes to DONE early.
REQ-035 Without GOL_STABLE_DETECT_EN: o_stable SHALL be tied to 0, no comparator is built, and runs always last i_steps generations.

Verification
REQ-036 Blinker: 8x8, WRAP=1, row3=8'b00011100, steps=1 -> rows 2,3,4 = 8'b00001000 and o_gen=1; steps=2 -> original pattern restored and o_gen=2.
REQ-037 Glider: 8x8 toroidal, steps=32 -> grid identical to load, o_done at cycle t+33, o_gen=32.
REQ-038 Stable detect (macro on): 2x2 block, steps=10 -> o_done at t+2, o_stable=1, o_gen=0; macro off -> o_done at t+11, o_stable=0.
REQ-039 WRAP=0: a live cell at (0,0) with live cells at (0,1) and (1,0), steps=1 -> (1,1) born and (0,0) survives; WRAP=1 with the same load also counts (7,7), (0,7) and (7,0).
REQ-040 Abort and edge cases: steps=5, i_abort in the 3rd RUN cycle -> o_gen=2, no o_done, o_load_ready=1 the next cycle; steps=0 -> o_done at t+1, grid unchanged; i_reset_n low mid-run -> all outputs 0 except o_load_ready=1.
